boardman_wb_intercon: RTL and testbench
=======================================

// Module: boardman_wb_intercon
// PURPOSE
//  Single-master WISHBONE interconnect directly downstream of the board-manager serial bridge.
//  Decodes the top address bits of each bridge request to one of NSLAVE slave ports and registers request and response.
//  Terminates unmapped or hung accesses with an error so the serial link never stalls.
//  Keeps a saturating count of timeout events for diagnostics.
// PARAMETERS
//  ADDR_WIDTH      22            byte address width of master and slave ports
//  DATA_WIDTH      32            data width; sel width = DATA_WIDTH/8
//  SEL_BITS        2             top address bits used for decode; NSLAVE = 2**SEL_BITS
//  SLAVE_PRESENT   4'b1111       bit n = 1: slave n exists; 0: its region is unmapped
//  TIMEOUT_CYCLES  1024          cycles in ACCESS before forced error termination (>= 2)
//  BAD_DATA        32'hBADADD00  read data returned on err/timeout
// PORTS
//  wb_clk_i         in   1        clock
//  wb_rst_i         in   1        synchronous active-high reset
//  wb_cyc_i         in   1        master cycle
//  wb_stb_i         in   1        master strobe
//  wb_we_i          in   1        master write enable
//  wb_adr_i         in   ADDR_W   master byte address
//  wb_dat_i         in   DATA_W   master write data
//  wb_sel_i         in   DATA_W/8 master byte selects
//  wb_dat_o         out  DATA_W   read data to master
//  wb_ack_o         out  1        one-cycle ack pulse to master
//  wb_err_o         out  1        one-cycle error pulse to master
//  wb_rty_o         out  1        one-cycle retry pulse to master
//  s_cyc_o          out  NSLAVE   per-slave cycle (one-hot or zero)
//  s_stb_o          out  NSLAVE   per-slave strobe (equal to s_cyc_o)
//  s_we_o           out  1        shared registered write enable
//  s_adr_o          out  ADDR_W   shared registered address
//  s_dat_o          out  DATA_W   shared registered write data
//  s_sel_o          out  DATA_W/8 shared registered selects
//  s_dat_i          in   NSLAVE*DATA_W packed slave read data, slave n at [n*DATA_W +: DATA_W]
//  s_ack_i/s_err_i/s_rty_i  in NSLAVE  per-slave terminations
//  timeout_count_o  out  8        saturating count of timeouts
// BEHAVIOUR
//  Reset (sync, active-high, any state): FSM=IDLE; all outputs 0; timeout counter cleared; timeout_count_o cleared.
//  FSM states: IDLE, ACCESS, RESPOND, RELEASE.
//  IDLE:
//   - on cyc&stb, latch we/adr/dat/sel; n = adr[ADDR_W-1 -: SEL_BITS].
//   - SLAVE_PRESENT[n]: -> ACCESS; s_cyc_o/s_stb_o[n] = 1 from the next cycle.
//   - else: -> RESPOND with err, wb_dat_o = BAD_DATA; slaves never strobed.
//  ACCESS:
//   - selected slave strobe held; timer counts each cycle.
//   - termination from selected slave only, priority err > rty > ack; terminations from other slaves ignored.
//   - on termination: latch s_dat_i[n] (ack) or BAD_DATA (err/rty), deassert strobe next cycle, -> RESPOND.
//   - timer reaches TIMEOUT_CYCLES: same as err, plus timeout_count_o += 1, saturating at 255.
//   - master drops stb or cyc: abort; strobe deasserted next cycle, -> IDLE, no response pulse.
//  RESPOND: exactly one of wb_ack_o/err_o/rty_o high for one cycle, wb_dat_o valid; -> RELEASE.
//  RELEASE: -> IDLE once wb_stb_i = 0. A held stb is never re-accepted as a new request.
//  Latency: a slave acking on its first strobe cycle gives wb_ack_o 2 cycles after the request is accepted in IDLE.
//   - unmapped access: err 1 cycle after acceptance.
//  wb_dat_o holds its last value outside RESPOND.
//  s_cyc_o is always one-hot or zero; never asserted outside ACCESS.
// STRUCTURE
//  Package boardman_wb_pkg holds:
//   - FSM state enum;
//   - response-type enum (ACK/ERR/RTY);
//   - BAD_DATA default.
//  Sub-module: none. Decode, timer and FSM live in one file.
// TESTING
//  1 Write 0x12345678 to 0x100004 (slave 1); slave acks on first strobe:
//    - s_stb_o = 4'b0010 for one cycle;
//    - wb_ack_o 2 cycles after acceptance.
//  2 Read slave 3 returning 0xCAFEF00D after 5 wait cycles -> wb_dat_o = 0xCAFEF00D with wb_ack_o; no other slave strobed.
//  3 SLAVE_PRESENT = 4'b0111, access 0x300000:
//    - wb_err_o after 1 cycle, wb_dat_o = 0xBADADD00;
//    - s_cyc_o stays 0.
//  4 Slave 0 never responds, TIMEOUT_CYCLES = 16:
//    - wb_err_o after 16 ACCESS cycles; timeout_count_o = 1.
//    - 300 further timeouts -> timeout_count_o = 255.
//  5 Slave asserts ack and err together -> only wb_err_o; master holds stb 3 cycles after err -> no second access.
//  6 Assert wb_rst_i mid-ACCESS -> next cycle all outputs 0, FSM IDLE; a new request completes normally.

Source files
------------

// File: rtl/boardman_wb_pkg.sv
// Shared types for the board-manager WISHBONE interconnect:
// FSM states, response kinds and the default error read data.
package boardman_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_e;

  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hBADADD00;

endpackage

// File: rtl/boardman_wb_intercon.sv
// Single-master WISHBONE interconnect behind the board-manager serial bridge.
// Registered address decode to NSLAVE ports, bus timeout and error termination.
module boardman_wb_intercon
  import boardman_wb_pkg::*;
#(
  parameter int                        ADDR_WIDTH     = 22,
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        SEL_BITS       = 2,
  parameter logic [(2**SEL_BITS)-1:0]  SLAVE_PRESENT  = '1,
  parameter int                        TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0]     BAD_DATA       = BAD_DATA_DEFAULT
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic                                  wb_cyc_i,
  input  logic                                  wb_stb_i,
  input  logic                                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0]                 wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                 wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]               wb_sel_i,
  output logic [DATA_WIDTH-1:0]                 wb_dat_o,
  output logic                                  wb_ack_o,
  output logic                                  wb_err_o,
  output logic                                  wb_rty_o,
  output logic [(2**SEL_BITS)-1:0]              s_cyc_o,
  output logic [(2**SEL_BITS)-1:0]              s_stb_o,
  output logic                                  s_we_o,
  output logic [ADDR_WIDTH-1:0]                 s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  input  logic [(2**SEL_BITS)*DATA_WIDTH-1:0]   s_dat_i,
  input  logic [(2**SEL_BITS)-1:0]              s_ack_i,
  input  logic [(2**SEL_BITS)-1:0]              s_err_i,
  input  logic [(2**SEL_BITS)-1:0]              s_rty_i,
  output logic [7:0]                            timeout_count_o
);

  localparam int NSLAVE = 2**SEL_BITS;
  localparam int TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_TOP = TW'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [SEL_BITS-1:0]     idx_q, idx_d;
  logic [NSLAVE-1:0]       s_cyc_q, s_cyc_d;
  logic                    s_we_q, s_we_d;
  logic [ADDR_WIDTH-1:0]   s_adr_q, s_adr_d;
  logic [DATA_WIDTH-1:0]   s_dat_q, s_dat_d;
  logic [DATA_WIDTH/8-1:0] s_sel_q, s_sel_d;
  logic [DATA_WIDTH-1:0]   dat_o_q, dat_o_d;
  logic                    ack_q, ack_d, err_q, err_d, rty_q, rty_d;
  logic [7:0]              tcnt_q, tcnt_d;

  logic [SEL_BITS-1:0]     req_idx_s;
  logic                    req_s;
  logic                    rsp_valid_s;
  rsp_e                    rsp_s;
  logic [DATA_WIDTH-1:0]   rsp_data_s;
  logic                    timed_out_s;

  assign req_idx_s = wb_adr_i[ADDR_WIDTH-1 -: SEL_BITS];
  assign req_s     = wb_cyc_i & wb_stb_i;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    s_cyc_d     = s_cyc_q;
    s_we_d      = s_we_q;
    s_adr_d     = s_adr_q;
    s_dat_d     = s_dat_q;
    s_sel_d     = s_sel_q;
    dat_o_d     = dat_o_q;
    tcnt_d      = tcnt_q;
    rsp_valid_s = 1'b0;
    rsp_s       = RSP_ACK;
    rsp_data_s  = s_dat_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    timed_out_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          s_we_d  = wb_we_i;
          s_adr_d = wb_adr_i;
          s_dat_d = wb_dat_i;
          s_sel_d = wb_sel_i;
          idx_d   = req_idx_s;
          timer_d = '0;
          if (SLAVE_PRESENT[req_idx_s]) begin
            s_cyc_d = NSLAVE'(1) << req_idx_s;
            state_d = ST_ACCESS;
          end else begin
            rsp_valid_s = 1'b1;
            rsp_s       = RSP_ERR;
            rsp_data_s  = BAD_DATA;
          end
        end else begin
          s_cyc_d = '0;
        end
      end
      ST_ACCESS: begin
        // Master abort wins over any termination arriving in the same cycle.
        if (!req_s) begin
          s_cyc_d = '0;
          state_d = ST_IDLE;
        end else if (s_err_i[idx_q]) begin
          rsp_valid_s = 1'b1;
          rsp_s       = RSP_ERR;
          rsp_data_s  = BAD_DATA;
        end else if (s_rty_i[idx_q]) begin
          rsp_valid_s = 1'b1;
          rsp_s       = RSP_RTY;
          rsp_data_s  = BAD_DATA;
        end else if (s_ack_i[idx_q]) begin
          rsp_valid_s = 1'b1;
          rsp_s       = RSP_ACK;
        end else if (timer_q == TIMER_TOP) begin
          rsp_valid_s = 1'b1;
          rsp_s       = RSP_ERR;
          rsp_data_s  = BAD_DATA;
          timed_out_s = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RESPOND: begin
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!wb_stb_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        s_cyc_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (rsp_valid_s) begin
      state_d = ST_RESPOND;
      s_cyc_d = '0;
      dat_o_d = rsp_data_s;
    end else begin
      dat_o_d = dat_o_q;
    end
    ack_d = rsp_valid_s && (rsp_s == RSP_ACK);
    err_d = rsp_valid_s && (rsp_s == RSP_ERR);
    rty_d = rsp_valid_s && (rsp_s == RSP_RTY);

    if (timed_out_s && (tcnt_q != 8'hFF)) begin
      tcnt_d = tcnt_q + 8'd1;
    end else begin
      tcnt_d = tcnt_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      s_cyc_q <= '0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      s_sel_q <= '0;
      dat_o_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      s_cyc_q <= s_cyc_d;
      s_we_q  <= s_we_d;
      s_adr_q <= s_adr_d;
      s_dat_q <= s_dat_d;
      s_sel_q <= s_sel_d;
      dat_o_q <= dat_o_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rty_q   <= rty_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign wb_dat_o        = dat_o_q;
  assign wb_ack_o        = ack_q;
  assign wb_err_o        = err_q;
  assign wb_rty_o        = rty_q;
  assign s_cyc_o         = s_cyc_q;
  assign s_stb_o         = s_cyc_q;
  assign s_we_o          = s_we_q;
  assign s_adr_o         = s_adr_q;
  assign s_dat_o         = s_dat_q;
  assign s_sel_o         = s_sel_q;
  assign timeout_count_o = tcnt_q;

endmodule

// File: tb/tb_boardman_wb_intercon.sv
// Directed bench for boardman_wb_intercon: one fully mapped instance (dut)
// and one with slave 3 unmapped (dut_b), both with a 16-cycle timeout.
module tb_boardman_wb_intercon;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [21:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [127:0] s_dat_i;
  logic [3:0]  s_ack_i, s_err_i, s_rty_i;

  logic [31:0] dat_o;
  logic        ack_o, err_o, rty_o;
  logic [3:0]  s_cyc_o, s_stb_o;
  logic        s_we_o;
  logic [21:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [7:0]  tcnt;

  logic [31:0] b_dat_o;
  logic        b_ack_o, b_err_o, b_rty_o;
  logic [3:0]  b_s_cyc_o, b_s_stb_o;
  logic        b_s_we_o;
  logic [21:0] b_s_adr_o;
  logic [31:0] b_s_dat_o;
  logic [3:0]  b_s_sel_o;
  logic [7:0]  b_tcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  boardman_wb_intercon #(.SLAVE_PRESENT(4'b1111), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_o),
    .wb_ack_o(ack_o), .wb_err_o(err_o), .wb_rty_o(rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .timeout_count_o(tcnt)
  );

  boardman_wb_intercon #(.SLAVE_PRESENT(4'b0111), .TIMEOUT_CYCLES(16)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(b_dat_o),
    .wb_ack_o(b_ack_o), .wb_err_o(b_err_o), .wb_rty_o(b_rty_o),
    .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o), .s_we_o(b_s_we_o), .s_adr_o(b_s_adr_o),
    .s_dat_o(b_s_dat_o), .s_sel_o(b_s_sel_o), .s_dat_i(128'd0),
    .s_ack_i(4'd0), .s_err_i(4'd0), .s_rty_i(4'd0),
    .timeout_count_o(b_tcnt)
  );

  // One clock cycle; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w, input logic [21:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0;
    s_ack_i = 4'd0; s_err_i = 4'd0; s_rty_i = 4'd0;
  endtask

  task automatic one_timeout();
    req(1'b0, 22'h000010, 32'd0);
    tick();
    repeat (16) tick();
    drop();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 22'd0; wdat = 32'd0; sel = 4'd0;
    s_dat_i = 128'd0; s_ack_i = 4'd0; s_err_i = 4'd0; s_rty_i = 4'd0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_cyc", {28'd0, s_cyc_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_tcnt", {24'd0, tcnt}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: write to slave 1, slave acks on its first strobe cycle
    req(1'b1, 22'h100004, 32'h12345678);
    tick();
    chk("t1_stb", {28'd0, s_stb_o}, 32'h2);
    chk("t1_ack_early", {31'd0, ack_o}, 32'd0);
    chk("t1_adr", {10'd0, s_adr_o}, 32'h100004);
    chk("t1_wdat", s_dat_o, 32'h12345678);
    chk("t1_we", {31'd0, s_we_o}, 32'd1);
    s_ack_i = 4'b0010;
    tick();
    chk("t1_ack", {31'd0, ack_o}, 32'd1);
    chk("t1_stb_off", {28'd0, s_stb_o}, 32'd0);
    drop();
    tick();
    chk("t1_ack_pulse", {31'd0, ack_o}, 32'd0);
    tick();

    // 2: read slave 3 with 5 wait cycles; a stray err from slave 0 is ignored
    req(1'b0, 22'h300000, 32'd0);
    s_dat_i[3*32 +: 32] = 32'hCAFEF00D;
    s_dat_i[0 +: 32]    = 32'h11111111;
    s_err_i = 4'b0001;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_stb", {28'd0, s_stb_o}, 32'h8);
      chk("t2_wait_noack", {30'd0, ack_o, err_o}, 32'd0);
      tick();
    end
    chk("t2_stb", {28'd0, s_stb_o}, 32'h8);
    s_ack_i = 4'b1000;
    tick();
    chk("t2_ack", {29'd0, ack_o, err_o, rty_o}, 32'h4);
    chk("t2_dat", dat_o, 32'hCAFEF00D);
    drop();
    tick();
    chk("t2_dat_hold", dat_o, 32'hCAFEF00D);
    tick();

    // 3: unmapped region on dut_b errs after one cycle; dut sees an abort
    req(1'b0, 22'h300000, 32'd0);
    tick();
    chk("t3_err", {31'd0, b_err_o}, 32'd1);
    chk("t3_dat", b_dat_o, 32'hBADADD00);
    chk("t3_cyc", {28'd0, b_s_cyc_o}, 32'd0);
    drop();
    tick();
    chk("t3_err_pulse", {31'd0, b_err_o}, 32'd0);
    chk("t3_cyc2", {28'd0, b_s_cyc_o}, 32'd0);
    chk("t3_abort_rsp", {29'd0, ack_o, err_o, rty_o}, 32'd0);
    chk("t3_abort_cyc", {28'd0, s_cyc_o}, 32'd0);
    tick();

    // 4: slave 0 never answers, 16-cycle timeout then counter saturation
    req(1'b0, 22'h000010, 32'd0);
    tick();
    repeat (15) tick();
    chk("t4_err_early", {31'd0, err_o}, 32'd0);
    chk("t4_stb_held", {28'd0, s_stb_o}, 32'h1);
    tick();
    chk("t4_err", {31'd0, err_o}, 32'd1);
    chk("t4_dat", dat_o, 32'hBADADD00);
    chk("t4_tcnt1", {24'd0, tcnt}, 32'd1);
    chk("t4_stb_off", {28'd0, s_stb_o}, 32'd0);
    drop();
    tick();
    tick();
    repeat (253) one_timeout();
    chk("t4_tcnt254", {24'd0, tcnt}, 32'd254);
    repeat (47) one_timeout();
    chk("t4_tcnt255", {24'd0, tcnt}, 32'd255);

    // 5: ack+err together gives err only; held stb is not re-accepted
    req(1'b1, 22'h200000, 32'hA5A5A5A5);
    tick();
    chk("t5_stb", {28'd0, s_stb_o}, 32'h4);
    s_ack_i = 4'b0100;
    s_err_i = 4'b0100;
    tick();
    chk("t5_rsp", {29'd0, ack_o, err_o, rty_o}, 32'h2);
    s_ack_i = 4'd0;
    s_err_i = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_stb", {28'd0, s_stb_o}, 32'd0);
      chk("t5_hold_rsp", {29'd0, ack_o, err_o, rty_o}, 32'd0);
    end
    drop();
    tick();
    tick();

    // 5b: rty outranks ack
    req(1'b0, 22'h200008, 32'd0);
    tick();
    s_ack_i = 4'b0100;
    s_rty_i = 4'b0100;
    tick();
    chk("t5b_rsp", {29'd0, ack_o, err_o, rty_o}, 32'h1);
    chk("t5b_dat", dat_o, 32'hBADADD00);
    drop();
    tick();
    tick();

    // 6: reset mid-access, then a fresh request completes
    req(1'b0, 22'h100000, 32'd0);
    s_dat_i[1*32 +: 32] = 32'h5A5A1234;
    tick();
    chk("t6_stb", {28'd0, s_stb_o}, 32'h2);
    rst = 1'b1;
    tick();
    chk("t6_rst_cyc", {28'd0, s_cyc_o}, 32'd0);
    chk("t6_rst_adr", {10'd0, s_adr_o}, 32'd0);
    chk("t6_rst_dat", dat_o, 32'd0);
    chk("t6_rst_tcnt", {24'd0, tcnt}, 32'd0);
    chk("t6_rst_rsp", {29'd0, ack_o, err_o, rty_o}, 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_new_stb", {28'd0, s_stb_o}, 32'h2);
    s_ack_i = 4'b0010;
    tick();
    chk("t6_new_ack", {31'd0, ack_o}, 32'd1);
    chk("t6_new_dat", dat_o, 32'h5A5A1234);
    drop();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
